i2c_bus_arbiter: RTL

- Shares one I2C master (cmd/data handshake interface) between NUM_REQ on-chip requesters, e.g. audio DAC streamer, clock-synth configurator, sensor poller.
- Grants the bus per transaction, round-robin.
- Forwards the granted requester's command/data signals to the master and routes responses back.
- Enforces a post-transaction gap so the master finishes STOP before the next START.
- Asks a long-running owner to yield when others wait.

---
 rtl/i2c_bus_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ on-chip requesters.
// A grant lasts one whole transaction. Each release is followed by a fixed idle
// gap, so the master can finish STOP before the next START. A long-running owner
// is asked to yield when another requester is waiting.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from rr_q+1
// OWN   | granted requester drives the master; responses routed back to it
// GAP   | post-release quiet time; no grant issued until the counter expires
module i2c_bus_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 64,
   parameter int MAX_BYTES  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_active_i,
   input  logic [7*NUM_REQ-1:0]   req_addr_i,
   input  logic [NUM_REQ-1:0]     req_read_i,
   input  logic [NUM_REQ-1:0]     req_high_speed_i,
   input  logic [NUM_REQ-1:0]     req_read_nack_i,
   input  logic [NUM_REQ-1:0]     req_data_valid_i,
   input  logic [8*NUM_REQ-1:0]   req_data_in_i,
   output logic [NUM_REQ-1:0]     req_grant_o,
   output logic [NUM_REQ-1:0]     req_yield_o,
   output logic [NUM_REQ-1:0]     req_data_ready_o,
   output logic [NUM_REQ-1:0]     req_addr_err_o,
   output logic [NUM_REQ-1:0]     req_data_err_o,
   output logic [7:0]             req_data_out_o,
   output logic                   m_cmd_active_o,
   output logic [6:0]             m_cmd_addr_o,
   output logic                   m_cmd_read_o,
   output logic                   m_cmd_high_speed_o,
   output logic                   m_read_nack_o,
   output logic                   m_data_valid_o,
   output logic [7:0]             m_data_in_o,
   input  logic                   m_data_ready_i,
   input  logic                   m_addr_err_i,
   input  logic                   m_data_err_i,
   input  logic [7:0]             m_data_out_i
);

   localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BC_W = $clog2(MAX_BYTES + 1);
   localparam int GC_W = $clog2(GAP_CYCLES + 1);
   localparam logic [RR_W-1:0] RR_RST  = RR_W'(NUM_REQ - 1);
   localparam logic [BC_W-1:0] BC_MAX  = BC_W'(MAX_BYTES);
   localparam logic [GC_W-1:0] GC_LOAD = GC_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_GAP} state_t;

   state_t               state_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [NUM_REQ-1:0]   grant_d;
   logic                 yield_q;
   logic [RR_W-1:0]      rr_q;
   logic [BC_W-1:0]      byte_cnt_q;
   logic [BC_W-1:0]      byte_cnt_d;
   logic [GC_W-1:0]      gap_cnt_q;

   logic                 in_own;
   logic                 own_active;
   logic                 handshake;
   logic                 others_pending;
   logic                 win_found;
   logic [RR_W-1:0]      win_idx;

   // rr_q always holds the current (or most recent) owner, so it doubles as the mux select
   assign in_own         = (state_q == ST_OWN);
   assign own_active     = req_active_i[rr_q];
   assign handshake      = m_data_valid_o & m_data_ready_i;
   assign others_pending = |(req_active_i & ~grant_q);
   assign byte_cnt_d     = (handshake && (byte_cnt_q != BC_MAX)) ? byte_cnt_q + 1'b1 : byte_cnt_q;

   // Round-robin search: first active requester above the last owner, wrapping around
   always_comb begin : p_search
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(rr_q) + off) % NUM_REQ;
         if (!win_found && req_active_i[idx]) begin
            win_found = 1'b1;
            win_idx   = RR_W'(idx);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_d[i] = (win_idx == RR_W'(i));
      end
   end

   // Forward the owner's command/data to the master; quiet outside OWN, and the
   // owner dropping its request closes the command in that same cycle
   always_comb begin
      m_cmd_active_o     = 1'b0;
      m_cmd_addr_o       = '0;
      m_cmd_read_o       = 1'b0;
      m_cmd_high_speed_o = 1'b0;
      m_read_nack_o      = 1'b0;
      m_data_valid_o     = 1'b0;
      m_data_in_o        = '0;
      if (in_own) begin
         m_cmd_active_o     = own_active;
         m_cmd_addr_o       = req_addr_i[7*rr_q +: 7];
         m_cmd_read_o       = req_read_i[rr_q];
         m_cmd_high_speed_o = req_high_speed_i[rr_q];
         m_read_nack_o      = req_read_nack_i[rr_q];
         m_data_valid_o     = own_active & req_data_valid_i[rr_q];
         m_data_in_o        = req_data_in_i[8*rr_q +: 8];
      end
   end

   // Responses go back on the granted bit only; the read byte is broadcast
   always_comb begin
      req_data_ready_o = '0;
      req_addr_err_o   = '0;
      req_data_err_o   = '0;
      if (in_own) begin
         req_data_ready_o = grant_q & {NUM_REQ{m_data_ready_i}};
         req_addr_err_o   = grant_q & {NUM_REQ{m_addr_err_i}};
         req_data_err_o   = grant_q & {NUM_REQ{m_data_err_i}};
      end
   end

   assign req_data_out_o = m_data_out_i;
   assign req_grant_o    = grant_q;
   assign req_yield_o    = grant_q & {NUM_REQ{yield_q}};

   // Arbitration FSM with grant, yield, byte and gap counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         yield_q    <= 1'b0;
         rr_q       <= RR_RST;
         byte_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_found) begin
                  grant_q    <= grant_d;
                  rr_q       <= win_idx;
                  byte_cnt_q <= '0;
                  yield_q    <= 1'b0;
                  state_q    <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (!own_active) begin
                  grant_q    <= '0;
                  yield_q    <= 1'b0;
                  byte_cnt_q <= '0;
                  gap_cnt_q  <= GC_LOAD;
                  state_q    <= ST_GAP;
               end else begin
                  byte_cnt_q <= byte_cnt_d;
                  // looks at the post-handshake count so the request shows up the cycle after the limiting byte
                  if ((byte_cnt_d == BC_MAX) && others_pending) begin
                     yield_q <= 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
